st7735_fill_sequencer: RTL and testbench

- Rectangle-fill controller for the ST7735 panel.
- Accepts one fill request (window corners plus RGB565 colour) and emits the command/data byte stream: CASET, RASET, RAMWR, then pixel data.
- Sits between the application logic and a byte-level SPI transmitter, using a valid/ready handshake on both sides.
- Runs only after the panel init sequence has completed; gating on init is the integrator's responsibility.

---
 rtl/st7735_fill_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_st7735_fill_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st7735_fill_sequencer.sv
// st7735_fill_sequencer: turns one rectangle-fill request into the ST7735
// byte stream CASET / RASET / RAMWR followed by N RGB565 pixels, presented
// to a byte-level transmitter through a valid/ready handshake.
module st7735_fill_sequencer #(
   parameter int WIDTH    = 160,
   parameter int HEIGHT   = 80,
   parameter int X_OFFSET = 1,
   parameter int Y_OFFSET = 26
) (
   input  logic        SYSTEM_CLK,
   input  logic        SYSTEM_RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_x0,
   input  logic [7:0]  req_y0,
   input  logic [7:0]  req_x1,
   input  logic [7:0]  req_y1,
   input  logic [15:0] req_color,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_dc,
   output logic        byte_last,
   input  logic        byte_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      HEADER,
      PIX_HI,
      PIX_LO
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  hdr_idx_q, hdr_idx_d;
   logic [14:0] pix_cnt_q, pix_cnt_d;
   logic [7:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
   logic [15:0] color_q, color_d;
   logic        done_q, done_d, err_q, err_d;

   // Window corners as transmitted: offsets applied in 16 bits, no truncation.
   logic [15:0] xs0, xs1, ys0, ys1;
   assign xs0 = 16'(x0_q) + 16'(X_OFFSET);
   assign xs1 = 16'(x1_q) + 16'(X_OFFSET);
   assign ys0 = 16'(y0_q) + 16'(Y_OFFSET);
   assign ys1 = 16'(y1_q) + 16'(Y_OFFSET);

   // Window checks and pixel count; the count is only used when the window is legal,
   // where each span fits 8 bits and the product fits 15 bits.
   logic        req_ok;
   logic [7:0]  span_x, span_y;
   logic [14:0] pix_total;
   assign req_ok    = (x0_q <= x1_q) && (int'(x1_q) < WIDTH) &&
                      (y0_q <= y1_q) && (int'(y1_q) < HEIGHT);
   assign span_x    = x1_q - x0_q + 8'd1;
   assign span_y    = y1_q - y0_q + 8'd1;
   assign pix_total = 15'(span_x) * 15'(span_y);

   logic [7:0] hdr_data;
   logic       hdr_dc;

   // Header byte selection: the three commands carry dc=0, their parameters dc=1.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      hdr_data = 8'h00;
      hdr_dc   = 1'b1;
      case (hdr_idx_q)
         4'd0:  begin hdr_data = 8'h2A; hdr_dc = 1'b0; end
         4'd1:  hdr_data = xs0[15:8];
         4'd2:  hdr_data = xs0[7:0];
         4'd3:  hdr_data = xs1[15:8];
         4'd4:  hdr_data = xs1[7:0];
         4'd5:  begin hdr_data = 8'h2B; hdr_dc = 1'b0; end
         4'd6:  hdr_data = ys0[15:8];
         4'd7:  hdr_data = ys0[7:0];
         4'd8:  hdr_data = ys1[15:8];
         4'd9:  hdr_data = ys1[7:0];
         4'd10: begin hdr_data = 8'h2C; hdr_dc = 1'b0; end
         default: ;
      endcase
   end

   // Next-state and Moore outputs; byte outputs depend only on registered state so they hold during stalls.
   always_comb begin
      state_d    = state_q;
      hdr_idx_d  = hdr_idx_q;
      pix_cnt_d  = pix_cnt_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      x1_d       = x1_q;
      y1_d       = y1_q;
      color_d    = color_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      req_ready  = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      byte_dc    = 1'b0;
      byte_last  = 1'b0;
      busy       = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               x0_d    = req_x0;
               y0_d    = req_y0;
               x1_d    = req_x1;
               y1_d    = req_y1;
               color_d = req_color;
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (req_ok) begin
               pix_cnt_d = pix_total;
               hdr_idx_d = 4'd0;
               state_d   = HEADER;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end

         HEADER: begin
            byte_valid = 1'b1;
            byte_data  = hdr_data;
            byte_dc    = hdr_dc;
            if (byte_ready) begin
               if (hdr_idx_q == 4'd10) begin
                  hdr_idx_d = 4'd0;
                  state_d   = PIX_HI;
               end else begin
                  hdr_idx_d = hdr_idx_q + 4'd1;
               end
            end
         end

         PIX_HI: begin
            byte_valid = 1'b1;
            byte_data  = color_q[15:8];
            byte_dc    = 1'b1;
            if (byte_ready) state_d = PIX_LO;
         end

         PIX_LO: begin
            byte_valid = 1'b1;
            byte_data  = color_q[7:0];
            byte_dc    = 1'b1;
            byte_last  = (pix_cnt_q == 15'd1);
            if (byte_ready) begin
               pix_cnt_d = pix_cnt_q - 15'd1;
               if (pix_cnt_q == 15'd1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = PIX_HI;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State, counters, latched request and the done/err pulse registers.
   always_ff @(posedge SYSTEM_CLK) begin
      // NOTE: the latched request is reset too, so an aborted fill leaves nothing behind.
      if (SYSTEM_RESET) begin
         state_q   <= IDLE;
         hdr_idx_q <= '0;
         pix_cnt_q <= '0;
         x0_q      <= '0;
         y0_q      <= '0;
         x1_q      <= '0;
         y1_q      <= '0;
         color_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q   <= state_d;
         hdr_idx_q <= hdr_idx_d;
         pix_cnt_q <= pix_cnt_d;
         x0_q      <= x0_d;
         y0_q      <= y0_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         color_q   <= color_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_st7735_fill_sequencer.sv
// Bench for st7735_fill_sequencer: a request driver pushes the expected byte
// stream and completion events into queues; a monitor on the falling edge
// pops and compares whatever the sequencer presents.
module tb_st7735_fill_sequencer;

   localparam int X_OFF = 1;
   localparam int Y_OFF = 26;

   logic        clk = 1'b0;
   logic        SYSTEM_RESET = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [7:0]  req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
   logic [15:0] req_color = '0;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_dc;
   logic        byte_last;
   logic        byte_ready = 1'b0;
   logic        busy, done, err;

   always #5 clk = ~clk;

   st7735_fill_sequencer dut (
      .SYSTEM_CLK   (clk),
      .SYSTEM_RESET (SYSTEM_RESET),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_x0       (req_x0),
      .req_y0       (req_y0),
      .req_x1       (req_x1),
      .req_y1       (req_y1),
      .req_color    (req_color),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_dc      (byte_dc),
      .byte_last    (byte_last),
      .byte_ready   (byte_ready),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   typedef struct {
      logic [7:0] data;
      logic       dc;
      logic       last;
   } byte_t;

   typedef struct {
      logic is_err;
      int   accept;
      int   exp_done;
   } txn_t;

   byte_t bq[$];
   txn_t  txq[$];

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   rst_active = 1'b1;
   bit   rand_ready = 1'b0;
   bit   started = 1'b0;
   bit   in_stream = 1'b0;
   bit   prev_stall = 1'b0;
   logic [9:0] prev_out = '0;
   int   last_xfer = -100;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: constant or roughly 60% random.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         byte_ready = rand_ready ? ($urandom_range(0, 9) < 6) : 1'b1;
      end
   end

   task automatic push_b(input int d, input bit dc, input bit last);
      byte_t b;
      b.data = 8'(d);
      b.dc   = dc;
      b.last = last;
      bq.push_back(b);
   endtask

   // Reference model: expected outcome of one accepted request.
   task automatic push_expect(input int x0, input int y0, input int x1, input int y1,
                              input logic [15:0] color, input int acc);
      txn_t t;
      int   n;
      bit   ok;
      ok = (x0 <= x1) && (x1 < 160) && (y0 <= y1) && (y1 < 80);
      t.is_err   = !ok;
      t.accept   = acc;
      t.exp_done = -1;
      if (ok) begin
         n = (x1 - x0 + 1) * (y1 - y0 + 1);
         push_b('h2A, 0, 0);
         push_b((x0 + X_OFF) / 256, 1, 0);
         push_b((x0 + X_OFF) % 256, 1, 0);
         push_b((x1 + X_OFF) / 256, 1, 0);
         push_b((x1 + X_OFF) % 256, 1, 0);
         push_b('h2B, 0, 0);
         push_b((y0 + Y_OFF) / 256, 1, 0);
         push_b((y0 + Y_OFF) % 256, 1, 0);
         push_b((y1 + Y_OFF) / 256, 1, 0);
         push_b((y1 + Y_OFF) % 256, 1, 0);
         push_b('h2C, 0, 0);
         for (int i = 0; i < n; i++) begin
            push_b(int'(color[15:8]), 1, 0);
            push_b(int'(color[7:0]), 1, i == n - 1);
         end
         if (!rand_ready) t.exp_done = acc + 13 + 2 * n;
      end
      txq.push_back(t);
   endtask

   task automatic send_req(input int x0, input int y0, input int x1, input int y1,
                           input logic [15:0] color, output int acc);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_x0    = 8'(x0);
      req_y0    = 8'(y0);
      req_x1    = 8'(x1);
      req_y1    = 8'(y1);
      req_color = color;
      acc = -1;
      for (int i = 0; i < 30000; i++) begin
         @(negedge clk);
         if (req_ready) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) check("req_accept_timeout", req_ready, 1);
      else push_expect(x0, y0, x1, y1, color, acc);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic flush();
      txq.delete();
      bq.delete();
      started    = 1'b0;
      in_stream  = 1'b0;
      prev_stall = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (txq.size() == 0) break;
      end
      check("idle_timeout_pending_txns", txq.size(), 0);
      if (txq.size() != 0) flush();
   endtask

   // Monitor: compares every presented byte and completion pulse against the queues.
   task automatic monitor_step();
      logic [9:0] cur;
      cur = {byte_data, byte_dc, byte_last};
      if (in_stream) check("valid_held_mid_txn", byte_valid, 1);
      if (req_valid && busy) check("ready_low_while_busy", req_ready, 0);
      if (byte_valid) begin
         if (txq.size() == 0 || txq[0].is_err) begin
            check("byte_without_txn", byte_valid, 0);
         end else begin
            if (!started) begin
               check("first_byte_cycle", cyc, txq[0].accept + 2);
               started   = 1'b1;
               in_stream = 1'b1;
            end
            if (prev_stall) check("stall_hold", cur, prev_out);
            if (byte_ready) begin
               if (bq.size() == 0) begin
                  check("byte_overrun", byte_valid & byte_ready, 0);
               end else begin
                  byte_t e;
                  e = bq.pop_front();
                  check("byte", cur, {e.data, e.dc, e.last});
                  if (e.last) begin
                     in_stream = 1'b0;
                     last_xfer = cyc;
                  end
               end
            end
         end
         prev_stall = !byte_ready;
         prev_out   = cur;
      end else begin
         prev_stall = 1'b0;
      end
      if (done) begin
         if (txq.size() == 0 || txq[0].is_err) begin
            check("done_without_txn", done, 0);
         end else begin
            check("done_cycle", cyc, last_xfer + 1);
            if (txq[0].exp_done >= 0) check("done_latency", cyc, txq[0].exp_done);
            check("done_ready_busy", {req_ready, busy}, 2'b10);
            void'(txq.pop_front());
            started = 1'b0;
         end
      end
      if (err) begin
         if (txq.size() == 0 || !txq[0].is_err) begin
            check("err_without_txn", err, 0);
         end else begin
            check("err_cycle", cyc, txq[0].accept + 2);
            check("err_ready", req_ready, 1);
            void'(txq.pop_front());
         end
      end
   endtask

   always @(negedge clk) if (!rst_active) monitor_step();

   initial begin
      int a1, a2, x0, x1, y0, y1, w;
      logic [15:0] col;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_values",
            {req_ready, byte_valid, byte_data, byte_dc, byte_last, busy, done, err},
            15'h4000);
      @(posedge clk);
      #1;
      SYSTEM_RESET = 1'b0;
      rst_active   = 1'b0;

      // Single pixel, constant ready.
      rand_ready = 1'b0;
      send_req(10, 5, 10, 5, 16'hF800, a1);
      wait_idle(200);

      // Full screen, constant ready.
      send_req(0, 0, 159, 79, 16'h07E0, a1);
      wait_idle(30000);

      // Single pixel, random ready.
      rand_ready = 1'b1;
      send_req(10, 5, 10, 5, 16'hF800, a1);
      wait_idle(500);
      rand_ready = 1'b0;

      // Rejected windows.
      send_req(0, 0, 160, 0, 16'h1111, a1);
      wait_idle(50);
      send_req(20, 0, 10, 0, 16'h2222, a1);
      wait_idle(50);
      send_req(0, 0, 0, 80, 16'h3333, a1);
      wait_idle(50);

      // Reset in the middle of a full-screen pixel stream.
      send_req(0, 0, 159, 79, 16'h07E0, a1);
      repeat (2000) @(posedge clk);
      #1;
      rst_active   = 1'b1;
      SYSTEM_RESET = 1'b1;
      flush();
      @(posedge clk);
      #1;
      check("reset_abort_outputs",
            {req_ready, byte_valid, byte_data, byte_dc, byte_last, busy, done, err},
            15'h4000);
      SYSTEM_RESET = 1'b0;
      flush();
      rst_active = 1'b0;
      send_req(10, 5, 10, 5, 16'hF800, a1);
      wait_idle(200);

      // Second request held while busy: accepted in the done cycle.
      send_req(10, 5, 10, 5, 16'hF800, a1);
      send_req(0, 0, 3, 1, 16'h1234, a2);
      check("second_accept_at_done", a2, a1 + 15);
      wait_idle(200);

      // Random windows under random ready, some deliberately illegal.
      rand_ready = 1'b1;
      for (int k = 0; k < 25; k++) begin
         col = 16'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            x0 = $urandom_range(0, 255);
            x1 = $urandom_range(0, 255);
            y0 = $urandom_range(0, 255);
            y1 = $urandom_range(0, 255);
         end else begin
            x0 = $urandom_range(0, 159);
            w  = 159 - x0;
            if (w > 7) w = 7;
            x1 = x0 + $urandom_range(0, w);
            y0 = $urandom_range(0, 79);
            w  = 79 - y0;
            if (w > 5) w = 5;
            y1 = y0 + $urandom_range(0, w);
         end
         send_req(x0, y0, x1, y1, col, a1);
         wait_idle(2000);
      end
      rand_ready = 1'b0;

      repeat (5) @(posedge clk);
      check("queues_drained", txq.size() + bq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
